// File: rtl/ttl_pkg.sv
// Shared constants for the TTL register/shifter emulations: mode select codes
// and chip-clock qualifier modes.
package ttl_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHUP = 2'b01;
  localparam logic [1:0] MODE_SHDN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam int CEN_LEVEL = 0;
  localparam int CEN_RISE  = 1;
  localparam int CEN_FALL  = 2;

endpackage

// File: rtl/ttl_univ_reg_sync_if.sv
// Control/data bundle of the universal TTL register: the driver side owns the
// chip-clock, mode and data inputs; the register side owns the outputs.
interface ttl_univ_reg_sync_if #(
  parameter int WIDTH = 8
);

  logic             Cen;
  logic             Clr_n;
  logic [1:0]       S;
  logic [WIDTH-1:0] D;
  logic             Sin_lo;
  logic             Sin_hi;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             Sout_hi;
  logic             Sout_lo;
  logic             Fire;

  modport master (
    output Cen, Clr_n, S, D, Sin_lo, Sin_hi,
    input  Q, Q_bar, Sout_hi, Sout_lo, Fire
  );

  modport slave (
    input  Cen, Clr_n, S, D, Sin_lo, Sin_hi,
    output Q, Q_bar, Sout_hi, Sout_lo, Fire
  );

endinterface

// File: rtl/ttl_cen_qual.sv
// Turns the emulated chip clock into a one-Clk-cycle Fire qualifier: level,
// rising-edge or falling-edge, using the previous Clk-sampled Cen value.
module ttl_cen_qual
  import ttl_pkg::*;
#(
  parameter int CEN_MODE = CEN_RISE
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Cen,
  output logic Fire
);

  // Idle level chosen so a Cen already at its active level on reset release
  // does not count as a fresh edge.
  localparam logic IDLE = (CEN_MODE == CEN_FALL) ? 1'b0 : 1'b1;

  logic r_last_cen;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_last_cen <= IDLE;
    else       r_last_cen <= Cen;
  end

  always_comb begin
    Fire = 1'b0;
    if (CEN_MODE == CEN_LEVEL)     Fire = Cen;
    else if (CEN_MODE == CEN_RISE) Fire = Cen & ~r_last_cen;
    else                           Fire = ~Cen & r_last_cen;
  end

endmodule

// File: rtl/ttl_univ_reg_sync.sv
// Synchronous emulation of 74174/74175/74194/74273-style registers: hold,
// shift up/down, parallel load and sync clear, gated by the qualified Cen.
module ttl_univ_reg_sync
  import ttl_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CEN_MODE  = CEN_RISE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                Clk,
  input logic                Reset,
  ttl_univ_reg_sync_if.slave bus
);

  logic             w_fire;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] r_q = RESET_VAL;

  ttl_cen_qual #(
    .CEN_MODE (CEN_MODE)
  ) u_cen_qual (
    .Clk   (Clk),
    .Reset (Reset),
    .Cen   (bus.Cen),
    .Fire  (w_fire)
  );

  // Shifts written with operators so WIDTH==1 degenerates to loading the serial input.
  always_comb begin
    w_q_nxt = r_q;
    case (bus.S)
      MODE_SHUP: w_q_nxt = (r_q << 1) | WIDTH'(bus.Sin_lo);
      MODE_SHDN: w_q_nxt = (r_q >> 1) | (WIDTH'(bus.Sin_hi) << (WIDTH - 1));
      MODE_LOAD: w_q_nxt = bus.D;
      default:   w_q_nxt = r_q;
    endcase
  end

  // Clear consumes a coincident Fire; the qualifier still tracks Cen.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           r_q <= RESET_VAL;
    else if (!bus.Clr_n) r_q <= '0;
    else if (w_fire)     r_q <= w_q_nxt;
  end

  assign bus.Q       = r_q;
  assign bus.Q_bar   = ~r_q;
  assign bus.Sout_hi = r_q[WIDTH-1];
  assign bus.Sout_lo = r_q[0];
  assign bus.Fire    = w_fire;

endmodule
